// File: rtl/billiard_aim_pkg.sv
// billiard_aim_pkg
// Shared types and helpers for the cue-aim controller.
//   aim_state_t : shot FSM states (AIM, FIRE, LOCKED)
//   aim_dir_t   : resolved keypad direction
//   sat_add     : add with symmetric clamp to [-vel_max, +vel_max]
package billiard_aim_pkg;

  typedef enum logic [1:0] {
    AIM    = 2'd0,
    FIRE   = 2'd1,
    LOCKED = 2'd2
  } aim_state_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_YM   = 3'd1,
    DIR_YP   = 3'd2,
    DIR_XM   = 3'd3,
    DIR_XP   = 3'd4
  } aim_dir_t;

  // The int sum is wider than VEL_W+1, so an in-range operand plus a step
  // can never wrap before it is clamped.
  function automatic int sat_add(input int a, input int b, input int vel_max);
    int s;
    s = a + b;
    if (s > vel_max) return vel_max;
    if (s < -vel_max) return -vel_max;
    return s;
  endfunction

endpackage

// File: rtl/aim_key_repeat.sv
// aim_key_repeat
// Turns the resolved direction into step pulses: one pulse when a direction
// becomes active (new press or change of key), then after REPEAT_DELAY held
// cycles, then every REPEAT_PERIOD cycles while still held.
// Ports:
//   clk        system clock
//   resetN     synchronous active-low reset
//   enable     high while keys are accepted; low clears repeat state
//   activeDir  direction currently requested
//   stepPulse  one-cycle step request (combinational, same cycle)
module aim_key_repeat
  import billiard_aim_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     enable,
  input  aim_dir_t activeDir,
  output logic     stepPulse
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  aim_dir_t         prevDir_q, prevDir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stepPulse = 1'b0;
    prevDir_d = DIR_NONE;
    cnt_d     = '0;
    if (enable && (activeDir != DIR_NONE)) begin
      prevDir_d = activeDir;
      if (activeDir != prevDir_q) begin
        stepPulse = 1'b1;
        cnt_d     = DELAY_LOAD;
      end else if (cnt_q == '0) begin
        stepPulse = 1'b1;
        cnt_d     = PERIOD_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      prevDir_q <= DIR_NONE;
      cnt_q     <= '0;
    end else begin
      prevDir_q <= prevDir_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/shot_aim_controller.sv
// shot_aim_controller
// Keypad-driven cue aim with hold-to-repeat, saturation and a shot lock.
//
//   state  | meaning
//   AIM    | aim line visible, direction keys step the aim, Enter may fire
//   FIRE   | one cycle: velocity strobe, aim optionally cleared
//   LOCKED | keys ignored until the balls have moved and stopped, or timeout
//
// Ports:
//   clk, resetN                  clock, synchronous active-low reset
//   key2/8/4/6IsPressed          direction levels (Y-, Y+, X-, X+)
//   keyEnterIsPressed            fire level
//   ballsMoving                  high while any ball moves
//   aimX, aimY                   current signed aim
//   aimActive                    high in AIM
//   newVelocityX/Y               shot velocity, held between shots
//   velocityWriteEnable          one-cycle strobe during FIRE
module shot_aim_controller
  import billiard_aim_pkg::*;
#(
  parameter int VEL_W         = 11,
  parameter int STEP          = 1,
  parameter int VEL_MAX       = 255,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter int LOCK_TIMEOUT  = 50_000_000,
  parameter int CLEAR_ON_FIRE = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    key2IsPressed,
  input  logic                    key8IsPressed,
  input  logic                    key4IsPressed,
  input  logic                    key6IsPressed,
  input  logic                    keyEnterIsPressed,
  input  logic                    ballsMoving,
  output logic signed [VEL_W-1:0] aimX,
  output logic signed [VEL_W-1:0] aimY,
  output logic                    aimActive,
  output logic signed [VEL_W-1:0] newVelocityX,
  output logic signed [VEL_W-1:0] newVelocityY,
  output logic                    velocityWriteEnable
);

  localparam int LCNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LCNT_W-1:0] LOCK_LOAD = LCNT_W'(LOCK_TIMEOUT - 1);

  // bit 0..3 = keys 2, 8, 4, 6 (priority order), bit 4 = Enter
  logic [4:0] keys;
  logic [4:0] keyPrev_q;
  logic [4:0] keyRise;
  logic [3:0] armed_q, armed_d;
  logic       enterEdge_q, enterEdge_d;
  logic       inAim;
  logic       stepPulse;
  aim_dir_t   activeDir;

  aim_state_t              state_q, state_d;
  logic signed [VEL_W-1:0] aimX_q, aimX_d, aimY_q, aimY_d;
  logic signed [VEL_W-1:0] nvX_q, nvX_d, nvY_q, nvY_d;
  logic [LCNT_W-1:0]       lockCnt_q, lockCnt_d;
  logic                    seenMoving_q, seenMoving_d;
  int                      dx, dy;

  assign keys    = {keyEnterIsPressed, key6IsPressed, key4IsPressed, key8IsPressed, key2IsPressed};
  assign keyRise = keys & ~keyPrev_q;
  assign inAim   = (state_q == AIM);

  // A key only counts once it has risen while in AIM; anything held through
  // reset or LOCKED stays inert until released and pressed again.
  assign armed_d     = keys[3:0] & (armed_q | keyRise[3:0]) & {4{inAim}};
  assign enterEdge_d = keyRise[4] & inAim;

  always_comb begin
    activeDir = DIR_NONE;
    if (armed_d[0])      activeDir = DIR_YM;
    else if (armed_d[1]) activeDir = DIR_YP;
    else if (armed_d[2]) activeDir = DIR_XM;
    else if (armed_d[3]) activeDir = DIR_XP;
  end

  aim_key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_repeat (
    .clk      (clk),
    .resetN   (resetN),
    .enable   (inAim),
    .activeDir(activeDir),
    .stepPulse(stepPulse)
  );

  always_comb begin
    state_d      = state_q;
    aimX_d       = aimX_q;
    aimY_d       = aimY_q;
    nvX_d        = nvX_q;
    nvY_d        = nvY_q;
    lockCnt_d    = lockCnt_q;
    seenMoving_d = seenMoving_q;
    dx           = 0;
    dy           = 0;

    case (activeDir)
      DIR_YM:  dy = -STEP;
      DIR_YP:  dy = STEP;
      DIR_XM:  dx = -STEP;
      DIR_XP:  dx = STEP;
      default: ;
    endcase

    case (state_q)
      AIM: begin
        if (stepPulse) begin
          aimX_d = VEL_W'(sat_add(int'(aimX_q), dx, VEL_MAX));
          aimY_d = VEL_W'(sat_add(int'(aimY_q), dy, VEL_MAX));
        end
        if (enterEdge_q && (keys[3:0] == 4'b0000) && ((aimX_q != '0) || (aimY_q != '0))) begin
          state_d = FIRE;
          nvX_d   = aimX_q;
          nvY_d   = aimY_q;
        end
      end
      FIRE: begin
        if (CLEAR_ON_FIRE != 0) begin
          aimX_d = '0;
          aimY_d = '0;
        end
        state_d      = LOCKED;
        lockCnt_d    = LOCK_LOAD;
        seenMoving_d = 1'b0;
      end
      LOCKED: begin
        if (ballsMoving) seenMoving_d = 1'b1;
        if (seenMoving_q && !ballsMoving) begin
          state_d = AIM;
        end else if (!seenMoving_q && !ballsMoving && (lockCnt_q == '0)) begin
          state_d = AIM;
        end else if (lockCnt_q != '0) begin
          lockCnt_d = lockCnt_q - LCNT_W'(1);
        end
      end
      default: state_d = AIM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      keyPrev_q    <= '1;
      armed_q      <= '0;
      enterEdge_q  <= 1'b0;
      state_q      <= AIM;
      aimX_q       <= '0;
      aimY_q       <= '0;
      nvX_q        <= '0;
      nvY_q        <= '0;
      lockCnt_q    <= '0;
      seenMoving_q <= 1'b0;
    end else begin
      keyPrev_q    <= keys;
      armed_q      <= armed_d;
      enterEdge_q  <= enterEdge_d;
      state_q      <= state_d;
      aimX_q       <= aimX_d;
      aimY_q       <= aimY_d;
      nvX_q        <= nvX_d;
      nvY_q        <= nvY_d;
      lockCnt_q    <= lockCnt_d;
      seenMoving_q <= seenMoving_d;
    end
  end

  assign aimX                = aimX_q;
  assign aimY                = aimY_q;
  assign newVelocityX        = nvX_q;
  assign newVelocityY        = nvY_q;
  assign aimActive           = inAim;
  assign velocityWriteEnable = (state_q == FIRE);

endmodule

// File: tb/tb_shot_aim_controller.sv
// tb_shot_aim_controller
// Directed vector table for the corner cases, then randomized keys, Enter,
// ballsMoving and resets checked against a behavioural model.
module tb_shot_aim_controller;

  localparam int VW = 11;
  localparam int M  = 3;
  localparam int D  = 4;
  localparam int P  = 2;
  localparam int LT = 8;

  localparam logic [3:0] NK = 4'b0000;
  localparam logic [3:0] K2 = 4'b0001;
  localparam logic [3:0] K8 = 4'b0010;
  localparam logic [3:0] K6 = 4'b1000;

  logic clk = 1'b0;
  logic resetN, k2, k8, k4, k6, ken, bm;
  logic signed [VW-1:0] aimX, aimY, nvX, nvY;
  logic aimActive, wen;

  always #5 clk = ~clk;

  shot_aim_controller #(
    .VEL_W(VW), .STEP(1), .VEL_MAX(M), .REPEAT_DELAY(D),
    .REPEAT_PERIOD(P), .LOCK_TIMEOUT(LT), .CLEAR_ON_FIRE(1)
  ) dut (
    .clk(clk), .resetN(resetN),
    .key2IsPressed(k2), .key8IsPressed(k8), .key4IsPressed(k4), .key6IsPressed(k6),
    .keyEnterIsPressed(ken), .ballsMoving(bm),
    .aimX(aimX), .aimY(aimY), .aimActive(aimActive),
    .newVelocityX(nvX), .newVelocityY(nvY), .velocityWriteEnable(wen)
  );

  typedef struct {
    logic [3:0] dk;
    logic       en;
    logic       bm;
    logic       rn;
    int         ex, ey, act, wen, nvx, nvy;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic add(input logic [3:0] dk, input logic en, input logic b, input logic rn,
                     input int ex, input int ey, input int act, input int w, input int nx, input int ny);
    vec_t v;
    v.dk = dk; v.en = en; v.bm = b; v.rn = rn;
    v.ex = ex; v.ey = ey; v.act = act; v.wen = w; v.nvx = nx; v.nvy = ny;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dk, input logic en, input logic b, input logic r);
    {k6, k4, k8, k2} = dk;
    ken = en;
    bm = b;
    resetN = r;
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int act,
                           input int w, input int nx, input int ny);
    chk({tag, " aimX"}, int'(aimX), ex);
    chk({tag, " aimY"}, int'(aimY), ey);
    chk({tag, " aimActive"}, int'(aimActive), act);
    chk({tag, " velocityWriteEnable"}, int'(wen), w);
    chk({tag, " newVelocityX"}, int'(nvX), nx);
    chk({tag, " newVelocityY"}, int'(nvY), ny);
  endtask

  // Behavioural model: modes 0=aiming 1=firing 2=locked. Repeat timing is
  // derived from how long the active direction has been held.
  int m_mode, m_ax, m_ay, m_nx, m_ny, m_cur, m_age, m_lockAge;
  bit m_down[4];
  bit m_usable[4];
  bit m_enPrev, m_enterLatched, m_seen;

  function automatic int clampv(input int v);
    if (v > M) return M;
    if (v < -M) return -M;
    return v;
  endfunction

  task automatic model_step(input logic [3:0] dk, input logic en, input logic b, input logic r);
    bit accepting, step, fireNow;
    int dir;
    if (!r) begin
      m_mode = 0; m_ax = 0; m_ay = 0; m_nx = 0; m_ny = 0;
      for (int i = 0; i < 4; i++) begin m_down[i] = 1'b1; m_usable[i] = 1'b0; end
      m_enPrev = 1'b1; m_enterLatched = 1'b0; m_cur = -1; m_age = 0;
      m_seen = 1'b0; m_lockAge = 0;
      return;
    end
    accepting = (m_mode == 0);
    dir = -1;
    for (int i = 0; i < 4; i++) begin
      m_usable[i] = dk[i] && accepting && (m_usable[i] || !m_down[i]);
      if (m_usable[i] && dir < 0) dir = i;
    end
    step = 1'b0;
    if (dir < 0) begin
      m_cur = -1; m_age = 0;
    end else if (dir != m_cur) begin
      m_cur = dir; m_age = 0; step = 1'b1;
    end else begin
      m_age++;
      step = (m_age >= D) && (((m_age - D) % P) == 0);
    end
    fireNow = m_enterLatched;
    m_enterLatched = en && !m_enPrev && accepting;
    m_enPrev = en;
    for (int i = 0; i < 4; i++) m_down[i] = dk[i];
    case (m_mode)
      0: begin
        if (step) begin
          case (dir)
            0: m_ay = clampv(m_ay - 1);
            1: m_ay = clampv(m_ay + 1);
            2: m_ax = clampv(m_ax - 1);
            default: m_ax = clampv(m_ax + 1);
          endcase
        end
        if (fireNow && dk == 4'b0000 && (m_ax != 0 || m_ay != 0)) begin
          m_nx = m_ax; m_ny = m_ay; m_mode = 1;
        end
      end
      1: begin
        m_ax = 0; m_ay = 0; m_mode = 2; m_lockAge = 0; m_seen = 1'b0;
      end
      default: begin
        if (m_seen && !b) m_mode = 0;
        else if (!m_seen && !b && m_lockAge >= LT - 1) m_mode = 0;
        else m_lockAge++;
        if (b) m_seen = 1'b1;
      end
    endcase
  endtask

  initial begin
    int yb[10];
    logic [3:0] rdk;
    logic ren, rbm, rrn;

    yb = '{-1, -1, -1, -1, -2, -2, -3, -3, -3, -3};

    // reset state and idle
    add(NK, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    // taps on key6 up to saturation
    for (int i = 0; i < 4; i++) begin
      add(K6, 0, 0, 1, (i < 3) ? i + 1 : 3, 0, 1, 0, 0, 0);
      add(NK, 0, 0, 1, (i < 3) ? i + 1 : 3, 0, 1, 0, 0, 0);
    end
    // key2 held: steps at 1,5,7,9 then saturated
    for (int i = 0; i < 10; i++) add(K2, 0, 0, 1, 3, yb[i], 1, 0, 0, 0);
    add(NK, 0, 0, 1, 3, -3, 1, 0, 0, 0);
    // fire with balls never moving: lock timeout after 8 cycles
    add(NK, 1, 0, 1, 3, -3, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 3, -3, 0, 1, 3, -3);
    for (int i = 0; i < LT; i++) add(NK, 0, 0, 1, 0, 0, 0, 0, 3, -3);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 3, -3);
    // Enter with zero aim is ignored
    add(NK, 1, 0, 1, 0, 0, 1, 0, 3, -3);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 3, -3);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 3, -3);
    // key2+key6: only Y moves; dropping key2 makes key6 a new press
    add(K2 | K6, 0, 0, 1, 0, -1, 1, 0, 3, -3);
    add(K2 | K6, 0, 0, 1, 0, -1, 1, 0, 3, -3);
    add(K6, 0, 0, 1, 1, -1, 1, 0, 3, -3);
    add(NK, 0, 0, 1, 1, -1, 1, 0, 3, -3);
    add(K6, 0, 0, 1, 2, -1, 1, 0, 3, -3);
    add(NK, 0, 0, 1, 2, -1, 1, 0, 3, -3);
    // fire (2,-1) with balls moving; keys ignored while locked
    add(NK, 1, 0, 1, 2, -1, 1, 0, 3, -3);
    add(NK, 0, 0, 1, 2, -1, 0, 1, 2, -1);
    add(NK, 0, 1, 1, 0, 0, 0, 0, 2, -1);
    add(K6, 0, 1, 1, 0, 0, 0, 0, 2, -1);
    add(K8, 0, 1, 1, 0, 0, 0, 0, 2, -1);
    add(K8, 0, 0, 1, 0, 0, 1, 0, 2, -1);
    // key8 held across unlock does nothing until re-pressed
    add(K8, 0, 0, 1, 0, 0, 1, 0, 2, -1);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 2, -1);
    add(K8, 0, 0, 1, 0, 1, 1, 0, 2, -1);
    add(NK, 0, 0, 1, 0, 1, 1, 0, 2, -1);
    // reset while key8 held
    add(K8, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(K8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(K8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(K8, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    // reset asserted in LOCKED
    add(NK, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 0, 1, 0, 1, 0, 1);
    add(NK, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(NK, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(NK, 0, 0, 1, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dk, vecs[i].en, vecs[i].bm, vecs[i].rn);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].act,
                vecs[i].wen, vecs[i].nvx, vecs[i].nvy);
    end

    rdk = 4'b0000; ren = 1'b0; rbm = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rrn = (c == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    rdk = 4'b0000;
          2, 3:    rdk = 4'(1 << $urandom_range(0, 3));
          default: rdk = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 5) == 0) ren = ~ren;
      if ($urandom_range(0, 7) == 0) rbm = ~rbm;
      drive(rdk, ren, rbm, rrn);
      model_step(rdk, ren, rbm, rrn);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", c), m_ax, m_ay, (m_mode == 0) ? 1 : 0,
                (m_mode == 1) ? 1 : 0, m_nx, m_ny);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
